// File: rtl/mem_stage_pkg.sv
// Shared bus sizes, field offsets and load-flag layout for the EX->ME and ME->WB buses.
package mem_stage_pkg;

  localparam int EX_DEST_LSB = 0;
  localparam int EX_GR_WE    = 5;
  localparam int EX_FROM_MEM = 6;
  localparam int EX_RES_LSB  = 7;
  localparam int EX_PC_LSB   = 39;
  localparam int EX_FLAG_LSB = 71;
  localparam int EX_FLAG_W   = 5;
  localparam int EX_ERTN     = 76;
  localparam int EX_SYSCALL  = 77;
  localparam int EX_to_ME_Bus_Size = EX_SYSCALL + 1;

  localparam int WB_DEST_LSB = 0;
  localparam int WB_GR_WE    = 5;
  localparam int WB_RES_LSB  = 6;
  localparam int WB_PC_LSB   = 38;
  localparam int WB_ERTN     = 70;
  localparam int WB_SYSCALL  = 71;
  localparam int ME_to_WB_Bus_Size = WB_SYSCALL + 1;

  typedef struct packed {
    logic       sign_ext;
    logic       is_byte;
    logic       is_half;
    logic [1:0] offset;
  } ld_flag_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake bundle around the ME stage: EX->ME input side and ME->WB output side.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                         EX_to_ME_Valid;
  logic [EX_to_ME_Bus_Size-1:0] EX_to_ME_Bus;
  logic                         ME_Allow_in;
  logic                         ME_to_WB_Valid;
  logic                         WB_Allow_in;
  logic [ME_to_WB_Bus_Size-1:0] ME_to_WB_Bus;

  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
  );

  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  ld_flag_t    flag,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (flag.offset)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = flag.offset[1] ? rdata[31:16] : rdata[15:0];

    // byte has priority when both size flags are set
    if (flag.is_byte)
      data = {{24{flag.sign_ext & b[7]}}, b};
    else if (flag.is_half)
      data = {{16{flag.sign_ext & h[15]}}, h};
    else
      data = rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX payload, aligns load data, drives WB and hazard info.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_stage_if.slave        pipe,
  input  logic [31:0]       data_sram_rdata,
  output logic [4:0]        ME_dest,
  output logic [31:0]       ME_Forward_Res,
  output logic              ME_to_ID_Ld_op,
  output logic              ME_to_ID_Sys_op,
  input  logic              excp_flush,
  input  logic              ertn_flush
);
  logic                         me_valid;
  logic                         me_ready_go;
  logic                         allow_in;
  logic [EX_to_ME_Bus_Size-1:0] ex_r;

  ld_flag_t    flag;
  logic        inst_syscall;
  logic        inst_ertn;
  logic [31:0] pc;
  logic [31:0] result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign me_ready_go = 1'b1;
  assign allow_in    = !me_valid | (me_ready_go & pipe.WB_Allow_in);

  // flush wins over a simultaneous accept
  always_ff @(posedge clk) begin
    if (reset | excp_flush | ertn_flush)
      me_valid <= 1'b0;
    else if (allow_in)
      me_valid <= pipe.EX_to_ME_Valid;
  end

  // payload deliberately has no reset; consumers qualify it with me_valid
  always_ff @(posedge clk) begin
    if (allow_in & pipe.EX_to_ME_Valid)
      ex_r <= pipe.EX_to_ME_Bus;
  end

  assign inst_syscall = ex_r[EX_SYSCALL];
  assign inst_ertn    = ex_r[EX_ERTN];
  assign flag         = ex_r[EX_FLAG_LSB +: EX_FLAG_W];
  assign pc           = ex_r[EX_PC_LSB +: 32];
  assign result       = ex_r[EX_RES_LSB +: 32];
  assign res_from_mem = ex_r[EX_FROM_MEM];
  assign gr_we        = ex_r[EX_GR_WE];
  assign dest         = ex_r[EX_DEST_LSB +: 5];

  load_align u_load_align (
    .rdata (data_sram_rdata),
    .flag  (flag),
    .data  (load_data)
  );

  assign final_result = res_from_mem ? load_data : result;

  always_comb begin
    pipe.ME_to_WB_Bus                      = '0;
    pipe.ME_to_WB_Bus[WB_SYSCALL]          = inst_syscall;
    pipe.ME_to_WB_Bus[WB_ERTN]             = inst_ertn;
    pipe.ME_to_WB_Bus[WB_PC_LSB +: 32]     = pc;
    pipe.ME_to_WB_Bus[WB_RES_LSB +: 32]    = final_result;
    pipe.ME_to_WB_Bus[WB_GR_WE]            = gr_we;
    pipe.ME_to_WB_Bus[WB_DEST_LSB +: 5]    = dest;
  end

  assign pipe.ME_Allow_in    = allow_in;
  assign pipe.ME_to_WB_Valid = me_valid & me_ready_go;

  assign ME_dest         = dest & {5{me_valid & gr_we}};
  assign ME_Forward_Res  = final_result;
  assign ME_to_ID_Ld_op  = me_valid & res_from_mem;
  assign ME_to_ID_Sys_op = me_valid & (inst_syscall | inst_ertn);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, ALU pass-through, stall, flush and reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_sram_rdata;
  logic [4:0]  ME_dest;
  logic [31:0] ME_Forward_Res;
  logic        ME_to_ID_Ld_op;
  logic        ME_to_ID_Sys_op;
  logic        excp_flush;
  logic        ertn_flush;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pipe            (ifc.slave),
    .data_sram_rdata (data_sram_rdata),
    .ME_dest         (ME_dest),
    .ME_Forward_Res  (ME_Forward_Res),
    .ME_to_ID_Ld_op  (ME_to_ID_Ld_op),
    .ME_to_ID_Sys_op (ME_to_ID_Sys_op),
    .excp_flush      (excp_flush),
    .ertn_flush      (ertn_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // EX->ME layout: syscall, ertn, {signed,byte,half,off[1:0]}, pc, result, res_from_mem, gr_we, dest
  function automatic logic [77:0] ex_bus(input logic sys, input logic ertn, input logic [4:0] flag,
                                         input logic [31:0] pc, input logic [31:0] res,
                                         input logic mem, input logic we, input logic [4:0] dest);
    return {sys, ertn, flag, pc, res, mem, we, dest};
  endfunction

  function automatic logic [71:0] wb_bus(input logic sys, input logic ertn, input logic [31:0] pc,
                                         input logic [31:0] res, input logic we, input logic [4:0] dest);
    return {sys, ertn, pc, res, we, dest};
  endfunction

  task automatic send(input logic [77:0] b);
    @(negedge clk);
    ifc.EX_to_ME_Valid = 1'b1;
    ifc.EX_to_ME_Bus   = b;
    @(posedge clk);
    #1;
    ifc.EX_to_ME_Valid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [4:0] flag, input logic [31:0] rdata,
                           input logic [31:0] exp);
    send(ex_bus(1'b0, 1'b0, flag, 32'h1c00_0100, 32'h0000_0000, 1'b1, 1'b1, 5'd3));
    data_sram_rdata = rdata;
    #1;
    check({tag, "_fwd"}, {40'h0, ME_Forward_Res}, {40'h0, exp});
    check({tag, "_bus"}, ifc.ME_to_WB_Bus, wb_bus(1'b0, 1'b0, 32'h1c00_0100, exp, 1'b1, 5'd3));
  endtask

  logic [77:0] pay_a, pay_b, pay_c;

  initial begin
    reset = 1'b1;
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
    data_sram_rdata = '0;
    ifc.EX_to_ME_Valid = 1'b0;
    ifc.EX_to_ME_Bus   = '0;
    ifc.WB_Allow_in    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd0);
    check("rst_allow_in", {71'h0, ifc.ME_Allow_in}, 72'd1);
    check("rst_dest", {67'h0, ME_dest}, 72'd0);
    check("rst_ld_op", {71'h0, ME_to_ID_Ld_op}, 72'd0);
    check("rst_sys_op", {71'h0, ME_to_ID_Sys_op}, 72'd0);
    @(negedge clk);
    reset = 1'b0;

    load_case("ld_b",      5'b11010, 32'h1280_3456, 32'hFFFF_FF80);
    check("ld_op", {71'h0, ME_to_ID_Ld_op}, 72'd1);
    check("ld_wb_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd1);
    load_case("ld_bu",     5'b01010, 32'h1280_3456, 32'h0000_0080);
    load_case("ld_b_off3", 5'b11011, 32'h1280_3456, 32'h0000_0012);
    load_case("ld_h",      5'b10110, 32'h8001_7FFF, 32'hFFFF_8001);
    load_case("ld_h_odd",  5'b10111, 32'h8001_7FFF, 32'hFFFF_8001);
    load_case("ld_hu",     5'b00100, 32'h8001_7FFF, 32'h0000_7FFF);
    load_case("ld_w",      5'b00000, 32'h8001_7FFF, 32'h8001_7FFF);
    load_case("ld_bh",     5'b11100, 32'h1280_3456, 32'h0000_0056);

    send(ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0200, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd5));
    #1;
    check("alu_dest", {67'h0, ME_dest}, 72'd5);
    check("alu_fwd", {40'h0, ME_Forward_Res}, {40'h0, 32'hDEAD_BEEF});
    check("alu_ld_op", {71'h0, ME_to_ID_Ld_op}, 72'd0);
    check("alu_bus", ifc.ME_to_WB_Bus, wb_bus(1'b0, 1'b0, 32'h1c00_0200, 32'hDEAD_BEEF, 1'b1, 5'd5));
    send(ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0204, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd5));
    #1;
    check("nowe_dest", {67'h0, ME_dest}, 72'd0);

    send(ex_bus(1'b1, 1'b0, 5'b0, 32'h1c00_0208, 32'h0, 1'b0, 1'b0, 5'd0));
    #1;
    check("sys_op", {71'h0, ME_to_ID_Sys_op}, 72'd1);
    check("sys_bus_bit", {71'h0, ifc.ME_to_WB_Bus[71]}, 72'd1);
    send(ex_bus(1'b0, 1'b1, 5'b0, 32'h1c00_020c, 32'h0, 1'b0, 1'b0, 5'd0));
    #1;
    check("ertn_op", {71'h0, ME_to_ID_Sys_op}, 72'd1);

    // stall: A held for 3 cycles while B waits on the EX side
    pay_a = ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0300, 32'h1111_1111, 1'b0, 1'b1, 5'd7);
    pay_b = ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0304, 32'h2222_2222, 1'b0, 1'b1, 5'd8);
    send(pay_a);
    ifc.WB_Allow_in    = 1'b0;
    ifc.EX_to_ME_Valid = 1'b1;
    ifc.EX_to_ME_Bus   = pay_b;
    #1;
    check("stall_allow", {71'h0, ifc.ME_Allow_in}, 72'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_bus", ifc.ME_to_WB_Bus, wb_bus(1'b0, 1'b0, 32'h1c00_0300, 32'h1111_1111, 1'b1, 5'd7));
      check("stall_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd1);
      check("stall_allow_h", {71'h0, ifc.ME_Allow_in}, 72'd0);
    end
    @(negedge clk);
    ifc.WB_Allow_in = 1'b1;
    #1;
    check("release_allow", {71'h0, ifc.ME_Allow_in}, 72'd1);
    @(posedge clk);
    #1;
    ifc.EX_to_ME_Valid = 1'b0;
    check("release_bus_b", ifc.ME_to_WB_Bus, wb_bus(1'b0, 1'b0, 32'h1c00_0304, 32'h2222_2222, 1'b1, 5'd8));
    check("release_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd1);

    // exception flush beats a simultaneous accept of a load+syscall
    @(negedge clk);
    ifc.EX_to_ME_Valid = 1'b1;
    ifc.EX_to_ME_Bus   = ex_bus(1'b1, 1'b0, 5'b0, 32'h1c00_0400, 32'h0, 1'b1, 1'b1, 5'd9);
    excp_flush = 1'b1;
    #1;
    check("flush_pre_allow", {71'h0, ifc.ME_Allow_in}, 72'd1);
    @(posedge clk);
    #1;
    excp_flush = 1'b0;
    ifc.EX_to_ME_Valid = 1'b0;
    check("flush_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd0);
    check("flush_sys_op", {71'h0, ME_to_ID_Sys_op}, 72'd0);
    check("flush_ld_op", {71'h0, ME_to_ID_Ld_op}, 72'd0);
    check("flush_dest", {67'h0, ME_dest}, 72'd0);

    send(ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0410, 32'h5, 1'b0, 1'b1, 5'd4));
    @(negedge clk);
    ertn_flush = 1'b1;
    @(posedge clk);
    #1;
    ertn_flush = 1'b0;
    check("ertn_flush_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd0);

    // reset during a stall
    pay_c = ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0500, 32'h3333_3333, 1'b1, 1'b1, 5'd12);
    send(pay_c);
    ifc.WB_Allow_in = 1'b0;
    @(posedge clk);
    #1;
    check("rs_stalled", {67'h0, ME_dest}, 72'd12);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rs_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd0);
    check("rs_allow", {71'h0, ifc.ME_Allow_in}, 72'd1);
    check("rs_dest", {67'h0, ME_dest}, 72'd0);
    check("rs_ld_op", {71'h0, ME_to_ID_Ld_op}, 72'd0);

    // back-to-back, one per cycle
    ifc.WB_Allow_in = 1'b1;
    @(negedge clk);
    ifc.EX_to_ME_Valid = 1'b1;
    ifc.EX_to_ME_Bus   = ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0600, 32'hA, 1'b0, 1'b1, 5'd20);
    @(posedge clk);
    #1;
    ifc.EX_to_ME_Bus   = ex_bus(1'b0, 1'b0, 5'b0, 32'h1c00_0604, 32'hB, 1'b0, 1'b1, 5'd21);
    check("b2b_first", {67'h0, ME_dest}, 72'd20);
    @(posedge clk);
    #1;
    ifc.EX_to_ME_Valid = 1'b0;
    check("b2b_second", {67'h0, ME_dest}, 72'd21);
    check("b2b_fwd", {40'h0, ME_Forward_Res}, 72'hB);
    check("b2b_valid", {71'h0, ifc.ME_to_WB_Valid}, 72'd1);
    @(posedge clk);
    #1;
    check("b2b_drain", {71'h0, ifc.ME_to_WB_Valid}, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that consumes the EX-to-ME bus and the data SRAM read data.
- Registers the incoming EX payload under a valid/allow-in handshake.
- Extracts and sign- or zero-extends load data from the 32-bit SRAM word using the byte/half/offset flags, selects the final writeback value and emits the ME-to-WB bus.
- Supplies forwarding, load-use and system-op hazard info back to ID.

Parameters:
- EX_ME_W, 78, EX-to-ME bus width. Fields: inst_syscall[77], inst_ertn[76], dest_flag[75:71] = {signed, byte, half, offset[1:0]}, pc[70:39], result[38:7], res_from_mem[6], gr_we[5], dest[4:0].
- ME_WB_W, 72, ME-to-WB bus width. Fields: inst_syscall[71], inst_ertn[70], pc[69:38], final_result[37:6], gr_we[5], dest[4:0].

Ports:
- clk  in  1  clock; all state on posedge clk.
- reset  in  1  synchronous, active-high reset.
- EX_to_ME_Valid  in  1  EX payload valid.
- EX_to_ME_Bus  in  EX_ME_W  EX payload.
- ME_Allow_in  out  1  ME can accept a payload this cycle.
- ME_to_WB_Valid  out  1  ME payload valid toward WB.
- WB_Allow_in  in  1  WB can accept.
- ME_to_WB_Bus  out  ME_WB_W  payload to WB.
- data_sram_rdata  in  32  read word; valid in the cycle after the EX-stage request, i.e. while the load sits in ME.
- ME_dest  out  5  destination register for hazard checks; 0 when no write.
- ME_Forward_Res  out  32  forwarded value (final_result).
- ME_to_ID_Ld_op  out  1  valid load in ME.
- ME_to_ID_Sys_op  out  1  valid syscall/ertn in ME.
- excp_flush  in  1  exception flush.
- ertn_flush  in  1  ertn flush.

Behaviour:
- ME_ReadyGo = 1 (single-cycle stage).
- ME_Allow_in = !ME_Valid | (ME_ReadyGo & WB_Allow_in).
- ME_to_WB_Valid = ME_Valid & ME_ReadyGo.
- ME_Valid update:
  - reset or (excp_flush | ertn_flush): cleared to 0. Flush has priority over a simultaneous accept.
  - else if ME_Allow_in: loads EX_to_ME_Valid.
- Payload registers load only when ME_Allow_in & EX_to_ME_Valid. They are not cleared by reset; every output derived from them is masked by ME_Valid where stated.
- On a stall (ME_Valid & !WB_Allow_in): payload and ME_Valid hold; ME_Allow_in = 0.
- Load extraction, using the registered flags and live data_sram_rdata:
  - byte: b = rdata >> (8*offset), take b[7:0]; sign-extend if signed, else zero-extend.
  - half: h = offset[1] ? rdata[31:16] : rdata[15:0]; extend as for byte. offset[0] is ignored.
  - neither: full word.
  - byte and half both set is illegal; byte wins.
- final_result = res_from_mem ? load_data : result.
- ME_dest = dest & {5{ME_Valid & gr_we}}.
- ME_Forward_Res = final_result, unmasked; consumers gate with ME_dest.
- ME_to_ID_Ld_op = ME_Valid & res_from_mem.
- ME_to_ID_Sys_op = ME_Valid & (inst_syscall | inst_ertn).
- ME_to_WB_Bus carries the registered fields with final_result. WB qualifies the bus with ME_to_WB_Valid.
- Reset values: ME_Valid = 0, so ME_to_WB_Valid, ME_Allow_in = 1, ME_dest = 0, ME_to_ID_Ld_op = 0 and ME_to_ID_Sys_op = 0 take effect the cycle after reset is sampled.
- Reset during a stall discards the held payload.
- Back-to-back accepts with WB_Allow_in = 1 give one instruction per cycle, with no bubble.

Decomposition:
- Shared header entries: EX_to_ME_Bus_Size and ME_to_WB_Bus_Size, plus the field offset constants for both buses, so the producer and consumer stay consistent.
- One natural combinational sub-module, load_align: inputs rdata and the 5-bit flag, output the extended 32-bit value. Reusable for later ld/st extensions.

Test Plan:
- ld.b signed, offset 2, rdata 0x12_80_34_56 -> final_result 0xFFFFFF80; ld.bu same -> 0x00000080.
- ld.h signed, offset 2, rdata 0x8001_7FFF -> 0xFFFF8001; ld.hu offset 0 -> 0x00007FFF; ld.w -> 0x80017FFF.
- ALU op with res_from_mem = 0, result 0xDEADBEEF, gr_we = 1, dest 5 -> ME_dest 5, ME_Forward_Res 0xDEADBEEF; with gr_we = 0 -> ME_dest 0.
- WB_Allow_in = 0 for 3 cycles with a valid payload -> ME_Allow_in 0, bus stable; release -> payload handed to WB, next EX payload accepted the same cycle.
- excp_flush asserted while EX_to_ME_Valid = 1 and ME_Allow_in = 1 -> ME_Valid 0 next cycle, ME_to_ID_Sys_op and ME_to_ID_Ld_op 0.
- reset mid-stall -> next cycle ME_Valid 0, ME_Allow_in 1, ME_dest 0.
